// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the NOP returned on misaligned fetches, and the wait-counter width.
package instr_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          CNT_W     = 4;

endpackage

// File: rtl/instr_mem_responder_imem_array.sv
// Single-clock instruction RAM: one synchronous read port and one write port.
// A same-cycle read and write of one word returns the old data.
module instr_mem_responder_imem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // rd_data only moves on rd_en, so it stays stable while a response is held
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch responder: accepts a byte address, waits WAIT_STATES cycles, reads the
// instruction RAM and presents the word on a valid/ready response channel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request (unless flush is asserted)
// ST_WAIT | counting down wait states; RAM read issued when count hits 1
// ST_RESP | response held on rsp_* until rsp_ready or flush
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int OPD_WIDTH   = 32,
  parameter int PC_WIDTH    = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [PC_WIDTH-1:0]  req_addr,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OPD_WIDTH-1:0] rsp_instr,
  output logic [PC_WIDTH-1:0]  rsp_addr,
  output logic                 rsp_err,
  input  logic                 load_en,
  input  logic [PC_WIDTH-3:0]  load_addr,
  input  logic [OPD_WIDTH-1:0] load_data
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("instr_mem_responder: WAIT_STATES must be in 0..15");
  end

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [PC_WIDTH-1:0]    addr_q;
  logic                   data_sel;
  logic                   accept;
  logic                   go_resp;
  logic [PC_WIDTH-1:0]    rd_addr;
  logic [OPD_WIDTH-1:0]   ram_rdata;

  assign req_ready = (state == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  // go_resp marks the cycle the RAM read is issued; the response follows next cycle
  always_comb begin
    go_resp = 1'b0;
    rd_addr = addr_q;
    if (state == ST_IDLE && accept && WAIT_STATES == 0) begin
      go_resp = 1'b1;
      rd_addr = req_addr;
    end else if (state == ST_WAIT && !flush && cnt == CNT_W'(1)) begin
      go_resp = 1'b1;
    end
  end

  instr_mem_responder_imem_array #(
    .DATA_W (OPD_WIDTH),
    .ADDR_W (PC_WIDTH-2)
  ) u_imem (
    .clk     (clk),
    .rd_en   (go_resp),
    .rd_addr (rd_addr[PC_WIDTH-1:2]),
    .rd_data (ram_rdata),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data)
  );

  // data_sel picks RAM data only for aligned fetches; reset and misaligned give NOP
  assign rsp_instr = data_sel ? ram_rdata : OPD_WIDTH'(NOP_INSTR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_addr  <= '0;
      data_sel  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            cnt    <= CNT_W'(WAIT_STATES);
            if (WAIT_STATES != 0) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (flush || rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (go_resp) begin
        state     <= ST_RESP;
        rsp_valid <= 1'b1;
        rsp_addr  <= rd_addr;
        rsp_err   <= |rd_addr[1:0];
        data_sel  <= ~|rd_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: one instance with two wait states
// and one with none, sharing clock, reset, flush and the program-load port.
module tb_instr_mem_responder;

  localparam int OW = 32;
  localparam int PW = 12;
  localparam int AW = PW - 2;
  localparam logic [OW-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush     = 1'b0;
  logic          load_en   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [OW-1:0] load_data = '0;

  logic          a_req_valid = 1'b0;
  logic          a_req_ready;
  logic [PW-1:0] a_req_addr  = '0;
  logic          a_rsp_valid;
  logic          a_rsp_ready = 1'b0;
  logic [OW-1:0] a_rsp_instr;
  logic [PW-1:0] a_rsp_addr;
  logic          a_rsp_err;

  logic          b_req_valid = 1'b0;
  logic          b_req_ready;
  logic [PW-1:0] b_req_addr  = '0;
  logic          b_rsp_valid;
  logic          b_rsp_ready = 1'b0;
  logic [OW-1:0] b_rsp_instr;
  logic [PW-1:0] b_rsp_addr;
  logic          b_rsp_err;

  instr_mem_responder #(.OPD_WIDTH(OW), .PC_WIDTH(PW), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .flush(flush),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_instr(a_rsp_instr),
    .rsp_addr(a_rsp_addr), .rsp_err(a_rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instr_mem_responder #(.OPD_WIDTH(OW), .PC_WIDTH(PW), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .flush(flush),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr),
    .rsp_addr(b_rsp_addr), .rsp_err(b_rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [OW-1:0] instr;
    logic          err;
  } rsp_t;

  int            n_vec = 0;
  int            n_err = 0;
  rsp_t          q_a[$];
  rsp_t          q_b[$];
  rsp_t          ea, eb;
  logic [OW-1:0] mdl [0:(1<<AW)-1];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t expect_rsp(input logic [PW-1:0] a);
    rsp_t r;
    r.addr  = a;
    r.err   = (a[1:0] != 2'b00);
    r.instr = r.err ? NOP : mdl[a[PW-1:2]];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] idx, input logic [OW-1:0] data);
    load_en = 1'b1; load_addr = idx; load_data = data;
    step();
    load_en = 1'b0;
    mdl[idx] = data;
  endtask

  always @(negedge clk) begin
    if (!rst && a_rsp_valid && a_rsp_ready) begin
      if (q_a.size() == 0) check_val("a_sb_empty", q_a.size(), 1);
      else begin
        ea = q_a.pop_front();
        check_val("a_rsp", {a_rsp_addr, a_rsp_instr, a_rsp_err}, ea);
      end
    end
    if (!rst && b_rsp_valid && b_rsp_ready) begin
      if (q_b.size() == 0) check_val("b_sb_empty", q_b.size(), 1);
      else begin
        eb = q_b.pop_front();
        check_val("b_rsp", {b_rsp_addr, b_rsp_instr, b_rsp_err}, eb);
      end
    end
  end

  // two-wait-state fetch, optionally stalling the consumer for `stall` cycles
  task automatic fetch_a(input logic [PW-1:0] addr, input int stall);
    logic [PW+OW:0] cap;
    int n;
    a_rsp_ready = (stall == 0);
    a_req_valid = 1'b1; a_req_addr = addr;
    #1 check_val("a_req_ready_idle", a_req_ready, 1);
    q_a.push_back(expect_rsp(addr));
    step();
    a_req_valid = 1'b0;
    check_val("a_req_ready_wait", a_req_ready, 0);
    n = 0;
    while (!a_rsp_valid && n < 40) begin step(); n++; end
    check_val("a_latency", n, 2);
    if (stall > 0) begin
      cap = {a_rsp_addr, a_rsp_instr, a_rsp_err};
      for (int i = 0; i < stall; i++) begin
        step();
        check_val("a_hold", {a_rsp_valid, a_rsp_addr, a_rsp_instr, a_rsp_err}, {1'b1, cap});
        check_val("a_req_ready_resp", a_req_ready, 0);
      end
      a_rsp_ready = 1'b1;
    end
    step();
    check_val("a_back_idle", {a_rsp_valid, a_req_ready}, 2'b01);
    a_rsp_ready = 1'b0;
  endtask

  // zero-wait-state fetch; keep leaves req_valid high through RESP
  task automatic fetch_b(input logic [PW-1:0] addr, input bit keep);
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_addr = addr;
    #1 check_val("b_req_ready_idle", b_req_ready, 1);
    q_b.push_back(expect_rsp(addr));
    step();
    if (!keep) b_req_valid = 1'b0;
    check_val("b_latency1", b_rsp_valid, 1);
    check_val("b_req_ready_resp", b_req_ready, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step();
    load_word(10'd0, 32'h0000_0113);
    load_word(10'd1, 32'h0020_8193);
    load_word(10'd2, 32'h1111_1111);
    load_word(10'd3, 32'h0050_0093);
    load_word(10'd4, 32'h00A0_0213);
    step();
    rst = 1'b0;
    check_val("rst_state_a",
              {a_rsp_valid, a_rsp_err, a_rsp_addr, a_rsp_instr, a_req_ready},
              {1'b0, 1'b0, 12'h000, NOP, 1'b1});
    check_val("rst_state_b", {b_rsp_valid, b_rsp_err, b_rsp_addr, b_rsp_instr},
              {1'b0, 1'b0, 12'h000, NOP});

    fetch_a(12'h00C, 0);
    fetch_a(12'h00C, 5);
    fetch_a(12'h006, 0);
    fetch_a(12'h004, 2);

    // flush in the first WAIT cycle
    a_req_valid = 1'b1; a_req_addr = 12'h00C;
    step();
    a_req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1 check_val("a_flush_wait_ready", a_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check_val("a_flush_wait_novalid", a_rsp_valid, 0);
      step();
    end
    fetch_a(12'h010, 0);

    // flush while the response is held
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_addr = 12'h008;
    step();
    a_req_valid = 1'b0;
    for (int i = 0; i < 40 && !a_rsp_valid; i++) step();
    check_val("a_flush_resp_valid", a_rsp_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1 check_val("a_flush_resp_drop", {a_rsp_valid, a_req_ready}, 2'b01);

    // flush in IDLE blocks acceptance
    flush = 1'b1; b_req_valid = 1'b1; b_req_addr = 12'h000; b_rsp_ready = 1'b1;
    #1 check_val("b_flush_idle_ready", b_req_ready, 0);
    step();
    flush = 1'b0; b_req_valid = 1'b0;
    #1 check_val("b_flush_idle_noacc", b_rsp_valid, 0);
    step();

    // back-to-back zero-wait fetches: one per two cycles
    fetch_b(12'h000, 1);
    fetch_b(12'h004, 1);
    fetch_b(12'h008, 0);

    // write collides with the read: old word returned, new word later
    load_en = 1'b1; load_addr = 10'd2; load_data = 32'hDEAD_BEEF;
    fetch_b(12'h008, 0);
    load_en = 1'b0;
    mdl[2] = 32'hDEAD_BEEF;
    fetch_b(12'h008, 0);
    fetch_b(12'h002, 0);

    // reset in the middle of WAIT
    a_rsp_ready = 1'b1;
    a_req_valid = 1'b1; a_req_addr = 12'h00C;
    step();
    a_req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("a_rst_mid_wait",
              {a_rsp_valid, a_rsp_err, a_rsp_addr, a_rsp_instr, a_req_ready},
              {1'b0, 1'b0, 12'h000, NOP, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("a_rst_novalid", a_rsp_valid, 0);
    end
    fetch_a(12'h00C, 0);
    fetch_a(12'h008, 0);

    step(); step();
    check_val("sb_drain", q_a.size() + q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
